// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcodes, instruction field positions,
// immediate width and the register-writer classification.
package decode_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;
  localparam int IMM_W   = 14;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;
  localparam int RD_MSB = 23;
  localparam int RD_LSB = 19;
  localparam int RA_MSB = 18;
  localparam int RA_LSB = 14;
  localparam int RB_MSB = 13;
  localparam int RB_LSB = 9;

  localparam logic [7:0] OP_ADD      = 8'h00;
  localparam logic [7:0] OP_SUB      = 8'h01;
  localparam logic [7:0] OP_MUL      = 8'h02;
  localparam logic [7:0] OP_LDB      = 8'h10;
  localparam logic [7:0] OP_LDW      = 8'h11;
  localparam logic [7:0] OP_STB      = 8'h12;
  localparam logic [7:0] OP_STW      = 8'h13;
  localparam logic [7:0] OP_MOV      = 8'h14;
  localparam logic [7:0] OP_BEQ      = 8'h30;
  localparam logic [7:0] OP_JUMP     = 8'h31;
  localparam logic [7:0] OP_TLBWRITE = 8'h32;
  localparam logic [7:0] OP_IRET     = 8'h33;

  function automatic logic is_writer(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_MOV: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side, ALU-side, writeback and flush signals of the decode stage.
// slave = decode stage, master = surrounding pipeline.
interface decode_if
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  in_instr;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_op;
  logic [DATA_W-1:0]   out_val1;
  logic [DATA_W-1:0]   out_val2;
  logic [DATA_W-1:0]   out_store_data;
  logic [REG_AW-1:0]   out_dst;
  logic                out_dst_en;
  logic                out_illegal;
  logic                wb_en;
  logic [REG_AW-1:0]   wb_dst;
  logic [DATA_W-1:0]   wb_data;
  logic                flush;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_dst, wb_data, flush,
    output in_ready, out_valid, out_op, out_val1, out_val2, out_store_data,
           out_dst, out_dst_en, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_dst, wb_data, flush,
    input  in_ready, out_valid, out_op, out_val1, out_val2, out_store_data,
           out_dst, out_dst_en, out_illegal
  );
endinterface

// File: rtl/decode_regfile.sv
// Architectural register file: three combinational read ports, one write port,
// R0 hardwired to zero.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NRD-1:0][REG_AW-1:0]    raddr_i,
  output logic [NRD-1:0][DATA_W-1:0]    rdata_o,
  input  logic                          we_i,
  input  logic [REG_AW-1:0]             waddr_i,
  input  logic [DATA_W-1:0]             wdata_i
);
  logic [NREGS-1:0][DATA_W-1:0] mem_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdata_o[p] = (raddr_i[p] == '0) ? '0 : mem_q[raddr_i[p]];
  end

  always_ff @(posedge clock) begin
    if (reset)                        mem_q <= '0;
    else if (we_i && waddr_i != '0)   mem_q[waddr_i] <= wdata_i;
  end
endmodule

// File: rtl/decode_stage.sv
// Decode/operand-issue stage: regfile read, scoreboard hazard check, one-entry
// output register. Define DECODE_WB_BYPASS_EN to forward same-cycle writeback.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic     clock,
  input  logic     reset,
  decode_if.slave  dif
);
  typedef struct packed {
    logic [7:0]        op;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] dst;
    logic              dst_en;
    logic              illegal;
  } entry_t;

  logic [7:0]         op;
  logic [REG_AW-1:0]  rd, ra, rb;
  logic [DATA_W-1:0]  imm;
  logic [2:0][DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0]  opa, opb, opd;
  logic               hit_a, hit_b, hit_d;
  logic               use_a, use_b, use_d, hazard, accept;
  entry_t             dec, out_d, out_q;
  logic               out_valid_d, out_valid_q;
  logic [NREGS-1:0]   pend_d, pend_q;

  assign op  = dif.in_instr[OP_MSB:OP_LSB];
  assign rd  = dif.in_instr[RD_MSB:RD_LSB];
  assign ra  = dif.in_instr[RA_MSB:RA_LSB];
  assign rb  = dif.in_instr[RB_MSB:RB_LSB];
  assign imm = {{(DATA_W-IMM_W){dif.in_instr[IMM_W-1]}}, dif.in_instr[IMM_W-1:0]};

  decode_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(3)) u_rf (
    .clock   (clock),
    .reset   (reset),
    .raddr_i ({rd, rb, ra}),
    .rdata_o (rf_rdata),
    .we_i    (dif.wb_en),
    .waddr_i (dif.wb_dst),
    .wdata_i (dif.wb_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign hit_a = dif.wb_en && (dif.wb_dst == ra) && (ra != '0);
  assign hit_b = dif.wb_en && (dif.wb_dst == rb) && (rb != '0);
  assign hit_d = dif.wb_en && (dif.wb_dst == rd) && (rd != '0);
`else
  // Without forwarding the array still holds the old value this cycle.
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
  assign hit_d = 1'b0;
`endif

  assign opa = hit_a ? dif.wb_data : rf_rdata[0];
  assign opb = hit_b ? dif.wb_data : rf_rdata[1];
  assign opd = hit_d ? dif.wb_data : rf_rdata[2];

  always_comb begin
    dec        = '0;
    dec.op     = op;
    dec.dst    = rd;
    dec.dst_en = is_writer(op) && (rd != '0);
    use_a      = 1'b0;
    use_b      = 1'b0;
    use_d      = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_BEQ, OP_TLBWRITE, OP_IRET: begin
        dec.val1 = opa; dec.val2 = opb; use_a = 1'b1; use_b = 1'b1;
      end
      OP_LDB, OP_LDW, OP_JUMP: begin
        dec.val1 = opa; dec.val2 = imm; use_a = 1'b1;
      end
      OP_STB, OP_STW: begin
        dec.val1 = opa; dec.val2 = imm; dec.store_data = opd;
        use_a = 1'b1; use_d = 1'b1;
      end
      OP_MOV:  dec.val1 = imm;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign hazard = dif.in_valid &&
                  ((use_a && pend_q[ra] && !hit_a) ||
                   (use_b && pend_q[rb] && !hit_b) ||
                   (use_d && pend_q[rd] && !hit_d));

  assign dif.in_ready = (!out_valid_q || dif.out_ready) && !hazard && !dif.flush;
  assign accept       = dif.in_valid && dif.in_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (dif.flush || dif.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clears apply before the set so a same-cycle issue keeps its pending bit.
  always_comb begin
    pend_d = pend_q;
    if (dif.wb_en)                                     pend_d[dif.wb_dst] = 1'b0;
    if (dif.flush && out_valid_q && out_q.dst_en)      pend_d[out_q.dst]  = 1'b0;
    if (accept && dec.dst_en)                          pend_d[dec.dst]    = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
    end
  end

  assign dif.out_valid      = out_valid_q;
  assign dif.out_op         = out_q.op;
  assign dif.out_val1       = out_q.val1;
  assign dif.out_val2       = out_q.val2;
  assign dif.out_store_data = out_q.store_data;
  assign dif.out_dst        = out_q.dst;
  assign dif.out_dst_en     = out_q.dst_en;
  assign dif.out_illegal    = out_q.illegal;
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-issue stage directly upstream of the ALU. Accepts one 32-bit instruction per cycle from fetch, reads the register file, checks a scoreboard for pending writes, and presents opcode plus two operands to the ALU through a one-entry output register with valid/ready handshake. It owns the architectural register file, whose write port is driven by writeback.

## Interface
- DATA_W, 32, operand and register width
- NREGS, 32, architectural registers; R0 reads as zero

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  decode accepts in_instr this cycle
- in_instr  in  32  raw instruction
- out_valid  out  1  ALU-side entry valid
- out_ready  in  1  ALU-side consumer accepts entry
- out_op  out  8  opcode to ALU instr input
- out_val1, out_val2  out  DATA_W each  ALU operands
- out_store_data  out  DATA_W  R[rd] for stb/stw, else 0
- out_dst  out  5  destination register
- out_dst_en  out  1  instruction writes out_dst
- out_illegal  out  1  opcode not recognised
- wb_en  in  1  writeback write enable
- wb_dst  in  5  writeback register
- wb_data  in  DATA_W  writeback value
- flush  in  1  discard output entry and refuse input this cycle

## Operation
- Fields: op=[31:24], rd=[23:19], ra=[18:14], rb=[13:9], imm=sext([13:0]) to DATA_W.
- Operand selection: add/sub/mul (0x00–0x02), beq (0x30), tlbwrite (0x32), iret (0x33): val1=R[ra], val2=R[rb]. ldb/ldw/stb/stw (0x10–0x13), jump (0x31): val1=R[ra], val2=imm. mov (0x14): val1=imm, val2=0.
- out_dst_en=1 for add, sub, mul, ldb, ldw, mov, and only when rd≠0; 0 otherwise.
- Unknown opcode: out_op=op, val1=val2=0, out_dst_en=0, out_illegal=1; still issued.
- Scoreboard: NREGS pending bits. Set for out_dst when an entry with out_dst_en loads the output register. Cleared on wb_en for wb_dst. Same-cycle set and clear of the same register: set wins. R0 never pending.
- Hazard: any register actually read by the instruction (ra, rb, or rd for stores) is pending and is not being cleared by this cycle's writeback.
- in_ready = (!out_valid | out_ready) & !hazard & !flush. Hazard evaluation gates on in_valid.
- Register file: wb_en writes at clock edge; writes to R0 ignored.
- Flush: out_valid←0 next cycle; if the discarded entry had out_dst_en, clear its pending bit (a same-cycle issue cannot occur because in_ready=0).

## Timing
- Reset: out_valid=0, all pending bits 0, all registers 0, out_op/out_val*/out_store_data/out_dst=0, out_dst_en=0, out_illegal=0.
- Latency: accept at edge N, out_valid and all out_* fields stable from N+1 until handshake.
- Output fields hold while out_valid & !out_ready.
- Throughput: one instruction per cycle with no hazards and out_ready held 1.
- Back-to-back dependency (I2 reads I1's rd): I2 stalls until the cycle wb_en & wb_dst==rd. With the bypass, it is accepted in that cycle. Without the bypass, it is accepted one cycle later.
- Reset mid-stall or with out_valid=1: all state returns to reset values at the next edge; the entry is lost.

## Configuration
- DECODE_WB_BYPASS_EN defined: a same-cycle writeback to a read register forwards wb_data into the operand and counts as not pending.
- Not defined: the read returns the old array value. The hazard persists that cycle, costing one extra stall cycle per dependency.

## Structure
- Package decode_pkg:
  - opcode constants OP_ADD…OP_IRET (8-bit)
  - field bit positions
  - imm width 14
  - function is_writer(op)
- Sub-module regfile: NREGS×DATA_W, three combinational read ports, one synchronous write port, R0 hardwired zero.
- decode_stage holds the decode logic, scoreboard, hazard logic and output register.

## Test plan
- Reset, then write R1=5 and R2=7 via wb. Issue add r3,r1,r2 (0x00) -> next cycle out_op=0x00, val1=5, val2=7, out_dst=3, out_dst_en=1.
- ldw r4,r1,imm=0x3FFF -> val1=5, val2=0xFFFFFFFF.
- stw r2,r1,8 -> out_store_data=7, out_dst_en=0.
- add r3,r1,r2 followed by sub r5,r3,r1 -> sub stalls (in_ready=0).
  - Drive wb r3=12: with the macro, sub is accepted that cycle with val1=12; without it, sub is accepted one cycle later.
- Hold out_ready=0 for 3 cycles -> out_* stable, in_ready=0; release -> the next instruction issues one cycle later.
- Issue add r6,… then assert flush while out_valid=1 -> out_valid=0 next cycle, pending[6]=0. An instruction reading r6 issues without stall. Opcode 0x7F -> out_illegal=1, out_dst_en=0.
